tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL provide parameter NCH, default 4, number of output channels (power of two, 2..16).
REQ-003 clk  input  1  rising-edge clock; the block SHALL use one clock and a synchronous, active-high reset.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_data  input  WIDTH  serial word stream.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_sync  input  1  frame marker, qualified by in_valid; marks the slot-0 word.
REQ-008 out_data  output  NCH*WIDTH  channel holding registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  NCH  one-cycle pulse, bit k set when channel k is updated.
REQ-010 frame_done  output  1  one-cycle pulse when slot NCH-1 is captured.
REQ-011 sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 locked  output  1  high while the FSM is in LOCKED.

Function
REQ-013 The FSM SHALL have two states: HUNT and LOCKED.
REQ-014 The slot counter SHALL be clog2(NCH) bits wide and SHALL advance only on accepted words (in_valid=1), wrapping NCH-1 -> 0.
REQ-015 In HUNT, in_valid=1 and in_sync=0 words SHALL be dropped with no output change.
REQ-016 In HUNT, in_valid=1 and in_sync=1 SHALL write the word to channel 0, pulse out_valid[0], set slot=1 and enter LOCKED.
REQ-017 In LOCKED, a valid word at slot s with the expected sync (in_sync=1 iff s=0) SHALL be written to channel s and pulse out_valid[s]; slot SHALL become s+1 mod NCH.
REQ-018 In LOCKED, in_sync=1 at slot s!=0 SHALL pulse sync_err, write the word to channel 0, pulse out_valid[0], set slot=1 and remain in LOCKED (realign).
REQ-019 In LOCKED, in_sync=0 at slot 0 SHALL pulse sync_err, drop the word, and enter HUNT with slot=0.
REQ-020 frame_done SHALL pulse in the same cycle as out_valid[NCH-1].
REQ-021 Latency: a word accepted at rising edge N SHALL be visible on out_data, with its out_valid pulse, after edge N (registered outputs, 1 cycle).
REQ-022 Cycles with in_valid=0 SHALL change no state, counter or channel register; all pulses SHALL be 0.
REQ-023 Channel registers not being written SHALL hold their value.
REQ-024 At most one out_valid bit SHALL be high in any cycle.
REQ-025 locked SHALL be a registered decode of the state and SHALL change in the cycle after the transition edge.

Reset
REQ-026 With rst=1 at a rising edge: state=HUNT, slot=0, out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
REQ-027 rst SHALL override in_valid in the same cycle; a reset mid-frame SHALL discard the partial frame and require a new in_sync.

Structure
REQ-028 The state encoding constants (HUNT=0, LOCKED=1) SHALL live in the shared package tdm_pkg.
REQ-029 The slot counter SHALL be a sub-module, tdm_slot_cnt, with inputs clk, rst, inc and load1, and output slot.
REQ-030 The channel write decode SHALL be a plain one-hot decode of slot gated by the write enable.

Verification (WIDTH=8, NCH=4)
REQ-031 Reset, then words 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles -> out_data=0x44332211; out_valid = 1,2,4,8 on successive cycles; frame_done with 0x44; locked=1.
REQ-032 In HUNT: 0xAA (no sync), then 0x55 (sync) -> 0xAA dropped; channel 0 = 0x55; locked rises the cycle after.
REQ-033 Locked at slot 2: 0x99 with sync -> sync_err pulse, ch0=0x99, next word 0x77 goes to ch1.
REQ-034 After a full frame: slot-0 word 0x66 without sync -> sync_err pulse, no out_valid, locked=0, ch0 unchanged.
REQ-035 Frame with in_valid gaps (0,1,0,0,1...) -> same result as REQ-031; no pulses in gap cycles.
REQ-036 rst asserted after slot 1 -> all outputs 0; following non-sync words dropped until in_sync.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types for the TDM demultiplexer: framing FSM state encoding.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM demultiplexer: advances per accepted word, can be
// forced to slot 1 when a frame marker realigns the stream.
module tdm_slot_cnt #(
  parameter int NCH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   load1,
  output logic [$clog2(NCH)-1:0] slot
);

  localparam int SW = $clog2(NCH);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (inc) begin
      // NCH is a power of two, so the natural wrap gives NCH-1 -> 0.
      slot <= slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: splits a framed serial word stream into NCH channel
// holding registers, tracking frame alignment with a HUNT/LOCKED FSM.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_sync,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  output logic                 frame_done,
  output logic                 sync_err,
  output logic                 locked
);

  localparam int SW = $clog2(NCH);

  state_t          state;
  logic [SW-1:0]   slot;
  logic [SW-1:0]   wr_slot;
  logic [NCH-1:0]  wr_sel;
  logic            wr_en;
  logic            inc;
  logic            load1;
  logic            err;
  logic            lose_lock;

  tdm_slot_cnt #(.NCH(NCH)) u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .load1 (load1),
    .slot  (slot)
  );

  // Classify the current word against the framing rules.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    wr_en     = 1'b0;
    wr_slot   = slot;
    inc       = 1'b0;
    load1     = 1'b0;
    err       = 1'b0;
    lose_lock = 1'b0;
    if (in_valid) begin
      if (state == HUNT) begin
        if (in_sync) begin
          wr_en   = 1'b1;
          wr_slot = '0;
          load1   = 1'b1;
        end
      end else if (in_sync && (slot != '0)) begin
        // Early frame marker: restart the frame from this word.
        err     = 1'b1;
        wr_en   = 1'b1;
        wr_slot = '0;
        load1   = 1'b1;
      end else if (!in_sync && (slot == '0)) begin
        // Missing frame marker: alignment lost, counter already sits at 0.
        err       = 1'b1;
        lose_lock = 1'b1;
      end else begin
        wr_en = 1'b1;
        inc   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wr_sel[k] = wr_en && (wr_slot == SW'(k));
    end
  end

  // NOTE: the channel registers are reset because they drive outputs with a
  // defined post-reset value; a pure storage array would not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      out_valid  <= wr_sel;
      frame_done <= wr_sel[NCH-1];
      sync_err   <= err;
      locked     <= (state == LOCKED);
      for (int k = 0; k < NCH; k++) begin
        if (wr_sel[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
      if (lose_lock) begin
        state <= HUNT;
      end else if (load1) begin
        state <= LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed framing scenarios plus a
// randomized run against a rule-level reference model.
module tb_tdm_demux;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_sync = 1'b0;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           frame_done;
  logic           sync_err;
  logic           locked;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: alignment flag, expected slot, channel contents.
  bit             m_locked = 1'b0;
  int             m_slot = 0;
  logic [W-1:0]   m_ch [N];
  logic [N-1:0]   e_valid;
  logic           e_fd;
  logic           e_err;
  logic           e_locked;
  logic [N*W-1:0] e_data;

  tdm_demux #(.WIDTH(W), .NCH(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sync    (in_sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic model_write(input int k, input logic [W-1:0] d);
    m_ch[k] = d;
    e_valid = N'(1) << k;
    e_fd    = (k == N - 1);
  endtask

  task automatic model_step(input logic r, input logic v, input logic s,
                            input logic [W-1:0] d);
    e_valid = '0;
    e_fd    = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      e_locked = 1'b0;
      m_locked = 1'b0;
      m_slot   = 0;
      for (int k = 0; k < N; k++) m_ch[k] = '0;
    end else begin
      e_locked = m_locked;  // locked trails the state by one edge
      if (v) begin
        if (!m_locked) begin
          if (s) begin
            model_write(0, d);
            m_slot   = 1;
            m_locked = 1'b1;
          end
        end else if (s && m_slot != 0) begin
          e_err = 1'b1;
          model_write(0, d);
          m_slot = 1;
        end else if (!s && m_slot == 0) begin
          e_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          model_write(m_slot, d);
          m_slot = (m_slot + 1) % N;
        end
      end
    end
    for (int k = 0; k < N; k++) e_data[k*W +: W] = m_ch[k];
  endtask

  task automatic apply(input logic r, input logic v, input logic s,
                       input logic [W-1:0] d);
    rst      = r;
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    model_step(r, v, s, d);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 1'b1, 8'hC3);  // reset must win over a valid sync word
    n_checks++;
    if (out_data !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    n_checks++;
    if ({out_valid, frame_done, sync_err, locked} !== '0) begin
      n_errors++;
      $display("FAIL reset_flags: got valid=%b fd=%b err=%b lk=%b expected all 0",
               out_valid, frame_done, sync_err, locked);
    end
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] words [N];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) begin
      apply(1'b0, 1'b1, (i == 0), words[i]);
      n_checks++;
      if (out_valid !== (N'(1) << i) || frame_done !== (i == N - 1)) begin
        n_errors++;
        $display("FAIL frame_pulse%0d: got valid=%b fd=%b expected valid=%b fd=%b",
                 i, out_valid, frame_done, N'(1) << i, (i == N - 1));
      end
    end
    n_checks++;
    if (out_data !== 32'h44332211 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL frame_data: got %h lk=%b expected 44332211 lk=1", out_data, locked);
    end
  endtask

  task automatic test_hunt();
    apply(1'b1, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b1, 1'b0, 8'hAA);
    n_checks++;
    if (out_valid !== '0 || out_data !== '0 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL hunt_drop: got valid=%b data=%h lk=%b expected 0 0 0",
               out_valid, out_data, locked);
    end
    apply(1'b0, 1'b1, 1'b1, 8'h55);
    n_checks++;
    if (out_valid !== 4'b0001 || out_data[W-1:0] !== 8'h55 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL hunt_sync: got valid=%b ch0=%h lk=%b expected 0001 55 0",
               out_valid, out_data[W-1:0], locked);
    end
    apply(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (locked !== 1'b1 || out_valid !== '0) begin
      n_errors++;
      $display("FAIL hunt_lock: got lk=%b valid=%b expected 1 0000", locked, out_valid);
    end
  endtask

  task automatic test_realign();
    // Locked at slot 1 after test_hunt.
    apply(1'b0, 1'b1, 1'b0, 8'h22);
    apply(1'b0, 1'b1, 1'b1, 8'h99);
    n_checks++;
    if (sync_err !== 1'b1 || out_valid !== 4'b0001 || out_data[W-1:0] !== 8'h99) begin
      n_errors++;
      $display("FAIL realign_err: got err=%b valid=%b ch0=%h expected 1 0001 99",
               sync_err, out_valid, out_data[W-1:0]);
    end
    apply(1'b0, 1'b1, 1'b0, 8'h77);
    n_checks++;
    if (sync_err !== 1'b0 || out_valid !== 4'b0010 || out_data[2*W-1:W] !== 8'h77) begin
      n_errors++;
      $display("FAIL realign_next: got err=%b valid=%b ch1=%h expected 0 0010 77",
               sync_err, out_valid, out_data[2*W-1:W]);
    end
  endtask

  task automatic test_lost_sync();
    apply(1'b1, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b1, 1'b1, 8'h11);
    apply(1'b0, 1'b1, 1'b0, 8'h22);
    apply(1'b0, 1'b1, 1'b0, 8'h33);
    apply(1'b0, 1'b1, 1'b0, 8'h44);
    apply(1'b0, 1'b1, 1'b0, 8'h66);
    n_checks++;
    if (sync_err !== 1'b1 || out_valid !== '0 || out_data !== 32'h44332211) begin
      n_errors++;
      $display("FAIL lost_err: got err=%b valid=%b data=%h expected 1 0000 44332211",
               sync_err, out_valid, out_data);
    end
    apply(1'b0, 1'b1, 1'b0, 8'h13);
    n_checks++;
    if (locked !== 1'b0 || out_valid !== '0 || sync_err !== 1'b0) begin
      n_errors++;
      $display("FAIL lost_hunt: got lk=%b valid=%b err=%b expected 0 0000 0",
               locked, out_valid, sync_err);
    end
  endtask

  task automatic test_gaps();
    logic [2+W-1:0] seq [10];
    int idx;
    seq = '{{2'b00, 8'h00}, {2'b11, 8'h11}, {2'b00, 8'h00}, {2'b00, 8'h00},
            {2'b10, 8'h22}, {2'b00, 8'h00}, {2'b10, 8'h33}, {2'b00, 8'h00},
            {2'b00, 8'h00}, {2'b10, 8'h44}};
    idx = 0;
    apply(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, seq[i][W+1], seq[i][W], seq[i][W-1:0]);
      n_checks++;
      if (seq[i][W+1]) begin
        if (out_valid !== (N'(1) << idx) || frame_done !== (idx == N - 1)) begin
          n_errors++;
          $display("FAIL gap_word%0d: got valid=%b fd=%b expected valid=%b fd=%b",
                   idx, out_valid, frame_done, N'(1) << idx, (idx == N - 1));
        end
        idx++;
      end else if ({out_valid, frame_done, sync_err} !== '0) begin
        n_errors++;
        $display("FAIL gap_idle%0d: got valid=%b fd=%b err=%b expected all 0",
                 i, out_valid, frame_done, sync_err);
      end
    end
    n_checks++;
    if (out_data !== 32'h44332211) begin
      n_errors++;
      $display("FAIL gap_data: got %h expected 44332211", out_data);
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b1, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b1, 1'b1, 8'h11);
    apply(1'b0, 1'b1, 1'b0, 8'h22);
    apply(1'b1, 1'b1, 1'b0, 8'h33);
    n_checks++;
    if ({out_data, out_valid, frame_done, sync_err, locked} !== '0) begin
      n_errors++;
      $display("FAIL midrst_clear: got data=%h valid=%b fd=%b err=%b lk=%b expected all 0",
               out_data, out_valid, frame_done, sync_err, locked);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
      n_checks++;
      if (out_valid !== '0 || out_data !== '0 || sync_err !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst_drop%0d: got valid=%b data=%h err=%b expected 0 0 0",
                 i, out_valid, out_data, sync_err);
      end
    end
    apply(1'b0, 1'b1, 1'b1, 8'h5A);
    n_checks++;
    if (out_valid !== 4'b0001 || out_data !== 32'h0000005A) begin
      n_errors++;
      $display("FAIL midrst_resync: got valid=%b data=%h expected 0001 0000005a",
               out_valid, out_data);
    end
  endtask

  task automatic test_random();
    logic r, v, s;
    logic [W-1:0] d;
    apply(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 2) != 0);
      // Mostly well-formed framing so long locked runs occur, with faults mixed in.
      s = ($urandom_range(0, 9) < 8) ? (m_slot == 0) : 1'($urandom);
      d = 8'($urandom);
      apply(r, v, s, d);
      n_checks++;
      if (out_data !== e_data || out_valid !== e_valid) begin
        n_errors++;
        $display("FAIL rand_data@%0d: got data=%h valid=%b expected data=%h valid=%b",
                 i, out_data, out_valid, e_data, e_valid);
      end
      n_checks++;
      if (frame_done !== e_fd || sync_err !== e_err || locked !== e_locked) begin
        n_errors++;
        $display("FAIL rand_flags@%0d: got fd=%b err=%b lk=%b expected fd=%b err=%b lk=%b",
                 i, frame_done, sync_err, locked, e_fd, e_err, e_locked);
      end
      n_checks++;
      if ($countones(out_valid) > 1) begin
        n_errors++;
        $display("FAIL rand_onehot@%0d: got valid=%b expected at most one bit", i, out_valid);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) m_ch[k] = '0;
    test_reset();
    test_basic_frame();
    test_hunt();
    test_realign();
    test_lost_sync();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
